phase_rand_source: RTL and testbench
====================================

# phase_rand_source

Annealing random-phase source for the PE array. It generates, per PE, a random phase word plus a randomize-enable bit. The enable bit is asserted with a probability that decays over a run. Its outputs drive the `ena` / `in_self_phase` side of each PE's phase-randomization stage. It is the producer end of that interface: it replaces simulation-only `$random` with a synthesizable, seedable LFSR bank and a valid/ready handshake.

## Interface
- `NUM_PE`, 8, number of PEs served
- `PHASE_W`, 4, phase word width
- `PROB_W`, 8, probability width; enable probability = prob / 2^PROB_W
- `STEP_CYCLES`, 256, accepted transfers per annealing step (≥2, power of 2)
- `clk` in 1: clock
- `reset_n` in 1: asynchronous, active-low reset
- `seed_load` in 1: load LFSR bank from `seed` (honoured in IDLE/DONE only)
- `seed` in 32: seed value
- `start` in 1: begin a run (honoured in IDLE/DONE only)
- `init_prob` in PROB_W: starting probability, sampled on `start`
- `decay_shift` in 3: annealing shift; 0 = no decay
- `rand_valid` out 1: output word valid
- `rand_ready` in 1: consumer accepts word
- `rand_phase` out NUM_PE*PHASE_W: phase for PE i at bits [i*PHASE_W +: PHASE_W]
- `rand_ena` out NUM_PE: randomize-enable per PE
- `busy` out 1: state == RUN
- `done` out 1: state == DONE

## Operation
- One 32-bit Galois LFSR per PE, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right, feedback from bit 0.
- Seeding: LFSR_i <= `seed` ^ (i * 32'h9E37_79B9) (32-bit truncation). A result of 0 is replaced by 32'h0000_0001.
- Reset seed is 32'hACE1_2024, using the same per-PE derivation.
- Per PE i:
  - phase_i = LFSR_i[PHASE_W-1:0]
  - cmp_i = LFSR_i[31 -: PROB_W]
  - ena_i = (cmp_i < prob)
- `rand_phase` and `rand_ena` are forced to 0 whenever `rand_valid` = 0.
- The outputs are a function of registers only. There is no combinational path from `rand_ready` to any output.
- FSM:
  - IDLE: `start` → prob <= `init_prob`, step_cnt <= 0. Next state is RUN if `init_prob` != 0, otherwise DONE.
  - RUN: `rand_valid` = 1. On each handshake (valid & ready), all LFSRs step once and step_cnt increments.
    - When step_cnt == STEP_CYCLES-1 on a handshake, step_cnt wraps to 0 and prob updates.
    - Update rule: if `decay_shift` == 0, prob is unchanged. Otherwise d = prob >> `decay_shift`; if d == 0 then d = 1; prob <= prob − d.
    - If the updated prob == 0, go to DONE on the same edge.
  - DONE: `done` = 1, `rand_valid` = 0. `start` behaves as in IDLE; `seed_load` is accepted.
- `start` and `seed_load` in RUN are ignored. `seed_load` and `start` in the same cycle: both apply, and the first word uses the new seed.
- `decay_shift` is sampled at each step update, not latched.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, prob = 0, step_cnt = 0, LFSRs = reset seed
  - `rand_valid` = 0, `rand_phase` = 0, `rand_ena` = 0, `busy` = 0, `done` = 0
- `start` at edge N → `busy` = 1 and `rand_valid` = 1 from cycle N+1. The first word reflects the LFSR state at start.
- Throughput is one word per cycle while `rand_ready` = 1.
- Backpressure: while valid & !ready, all outputs are held stable and step_cnt and the LFSRs do not advance.
- The word accepted on a step edge uses the old prob. The new prob is visible from the next word.
- Final handshake at edge M → `rand_valid` = 0 and `done` = 1 from cycle M+1.
- Reset mid-RUN aborts the run with no further handshake. After reset release, the block stays in IDLE until `start`.

## Test plan
- Reset mid-RUN:
  - Stimulus: assert `reset_n` = 0 between edges while streaming.
  - Response: `rand_valid`, `busy`, `rand_ena` and `rand_phase` go to 0 without waiting for a clock edge; `done` = 0; no output until a new `start`.
- Seed derivation:
  - Stimulus: `seed_load` with `seed` = 0, then `start` with `init_prob` = 255 and `rand_ready` = 1.
  - Response: the first word has PE0 phase = 4'h1 (LFSR_0 = 1) and ena_0 = 1 (cmp 0 < 255). The second PE0 LFSR value is 32'h8020_0003.
- Zero probability:
  - Stimulus: `start` with `init_prob` = 0.
  - Response: `rand_valid` stays 0 throughout; `done` = 1 from the next cycle; `busy` never asserts.
- Backpressure:
  - Stimulus: hold `rand_ready` = 0 for 10 cycles in RUN, then set it to 1.
  - Response: `rand_phase` and `rand_ena` are bit-identical for all 10 cycles, and the sequence resumes without skipping a word.
- Decay schedule:
  - Stimulus: `STEP_CYCLES` = 4, `init_prob` = 3, `decay_shift` = 1, `rand_ready` = 1.
  - Response: prob steps 3→2→1→0 after handshakes 4, 8 and 12. `done` = 1 and `rand_valid` = 0 the cycle after handshake 12. Exactly 12 words are transferred.
- No decay and restart:
  - Stimulus: `decay_shift` = 0 for 1000 handshakes, then reset, then a new `start`.
  - Response: `busy` stays 1 and `done` stays 0 during the run. After reset, the output sequence restarts from the reset-seed values.

Source files
------------

// File: rtl/phase_rand_source.sv
// phase_rand_source: annealing random-phase source feeding the PE array phase-randomization stage.
// Ports: clk/reset_n (async active-low); seed_load/seed reload the LFSR bank; start/init_prob begin a run;
// decay_shift sets the annealing rate; rand_valid/rand_ready handshake a word of rand_phase
// (PHASE_W bits per PE) and rand_ena (one bit per PE); busy = running, done = run finished.
module phase_rand_source #(
    parameter int NUM_PE      = 8,
    parameter int PHASE_W     = 4,
    parameter int PROB_W      = 8,
    parameter int STEP_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        seed_load,
    input  logic [31:0]                 seed,
    input  logic                        start,
    input  logic [PROB_W-1:0]           init_prob,
    input  logic [2:0]                  decay_shift,
    output logic                        rand_valid,
    input  logic                        rand_ready,
    output logic [NUM_PE*PHASE_W-1:0]   rand_phase,
    output logic [NUM_PE-1:0]           rand_ena,
    output logic                        busy,
    output logic                        done
);
    localparam int          CW         = $clog2(STEP_CYCLES);
    localparam logic [31:0] POLY       = 32'h8020_0003;
    localparam logic [31:0] RESET_SEED = 32'hACE1_2024;
    localparam logic [1:0]  IDLE       = 2'd0;
    localparam logic [1:0]  RUN        = 2'd1;
    localparam logic [1:0]  DONE       = 2'd2;

    logic [1:0]        state;
    logic [PROB_W-1:0] prob;
    logic [CW-1:0]     step_cnt;
    logic [31:0]       lfsr [NUM_PE];
    logic [PROB_W-1:0] shifted, prob_next;
    logic              hs, load;

    // Each PE gets a decorrelated seed; the all-zero LFSR lock-up state is never loaded.
    function automatic logic [31:0] seed_of(input logic [31:0] s, input int i);
        logic [31:0] v;
        v = s ^ (32'(i) * 32'h9E37_79B9);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    assign rand_valid = (state == RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign hs         = rand_valid && rand_ready;
    assign load       = seed_load && (state != RUN);

    // A non-zero shift always removes at least 1 so the run is guaranteed to terminate.
    always_comb begin
        shifted   = prob >> decay_shift;
        prob_next = (decay_shift == 3'd0) ? prob
                  : prob - ((shifted == '0) ? PROB_W'(1) : shifted);
    end

    for (genvar g = 0; g < NUM_PE; g++) begin : g_out
        assign rand_phase[g*PHASE_W +: PHASE_W] = rand_valid ? lfsr[g][PHASE_W-1:0] : '0;
        assign rand_ena[g] = rand_valid && (lfsr[g][31 -: PROB_W] < prob);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PE; i++) lfsr[i] <= seed_of(RESET_SEED, i);
        end else if (load) begin
            for (int i = 0; i < NUM_PE; i++) lfsr[i] <= seed_of(seed, i);
        end else if (hs) begin
            for (int i = 0; i < NUM_PE; i++) lfsr[i] <= (lfsr[i] >> 1) ^ (lfsr[i][0] ? POLY : 32'd0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prob     <= '0;
            step_cnt <= '0;
        end else if (state != RUN) begin
            if (start) begin
                prob     <= init_prob;
                step_cnt <= '0;
                state    <= (init_prob != '0) ? RUN : DONE;
            end
        end else if (rand_ready) begin
            if (step_cnt == CW'(STEP_CYCLES - 1)) begin
                step_cnt <= '0;
                prob     <= prob_next;
                if (prob_next == '0) state <= DONE;
            end else begin
                step_cnt <= step_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_phase_rand_source.sv
// tb_phase_rand_source: directed self-checking bench for phase_rand_source.
module tb_phase_rand_source;
    localparam int NUM_PE = 8, PHASE_W = 4, PROB_W = 8, STEP_CYCLES = 4;

    logic        clk = 0, reset_n = 0, seed_load = 0, start = 0, rand_ready = 0;
    logic [31:0] seed = 0;
    logic [7:0]  init_prob = 0;
    logic [2:0]  decay_shift = 0;
    logic        rand_valid, busy, done;
    logic [31:0] rand_phase;
    logic [7:0]  rand_ena;
    int          checks = 0, errors = 0;
    logic [31:0] m_lfsr [NUM_PE];
    logic [7:0]  m_prob;
    logic [31:0] snap_phase;
    logic [7:0]  snap_ena;
    int          bad, words;

    always #5 clk = ~clk;

    phase_rand_source #(.NUM_PE(NUM_PE), .PHASE_W(PHASE_W), .PROB_W(PROB_W), .STEP_CYCLES(STEP_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed(seed), .start(start),
        .init_prob(init_prob), .decay_shift(decay_shift), .rand_valid(rand_valid), .rand_ready(rand_ready),
        .rand_phase(rand_phase), .rand_ena(rand_ena), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_seed(input logic [31:0] s);
        logic [31:0] v;
        for (int i = 0; i < NUM_PE; i++) begin
            v = s ^ (32'(i) * 32'h9E37_79B9);
            m_lfsr[i] = (v == 0) ? 32'd1 : v;
        end
    endtask

    task automatic m_step();
        for (int i = 0; i < NUM_PE; i++)
            m_lfsr[i] = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 32'h8020_0003) : (m_lfsr[i] >> 1);
    endtask

    function automatic logic [31:0] exp_phase();
        logic [31:0] v;
        for (int i = 0; i < NUM_PE; i++) v[i*4 +: 4] = m_lfsr[i][3:0];
        return v;
    endfunction

    function automatic logic [7:0] exp_ena();
        logic [7:0] v;
        for (int i = 0; i < NUM_PE; i++) v[i] = m_lfsr[i][31:24] < m_prob;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag);
        check({tag, "_phase"}, 64'(rand_phase), 64'(exp_phase()));
        check({tag, "_ena"}, 64'(rand_ena), 64'(exp_ena()));
    endtask

    initial begin
        m_seed(32'hACE1_2024);
        m_prob = 0;
        #2;
        check("rst_valid", 64'(rand_valid), 0);
        check("rst_phase", 64'(rand_phase), 0);
        check("rst_ena", 64'(rand_ena), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        tick();
        reset_n = 1;
        tick();
        tick();
        check("idle_valid", 64'(rand_valid), 0);

        seed_load = 1;
        seed = 32'd0;
        tick();
        seed_load = 0;
        m_seed(32'd0);
        start = 1;
        init_prob = 8'd255;
        decay_shift = 3'd0;
        rand_ready = 1;
        tick();
        start = 0;
        m_prob = 8'd255;
        check("seed_valid", 64'(rand_valid), 1);
        check("seed_busy", 64'(busy), 1);
        check("seed_pe0_phase", 64'(rand_phase[3:0]), 64'h1);
        check("seed_pe0to3_phase", 64'(rand_phase[15:0]), 64'hB291);
        check("seed_pe0to3_ena", 64'(rand_ena[3:0]), 64'hF);
        check_word("w0");
        tick();
        m_step();
        check("w1_pe0_lfsr_model", 64'(m_lfsr[0]), 64'h8020_0003);
        check("w1_pe0_phase", 64'(rand_phase[3:0]), 64'h3);
        check("w1_pe0_ena", 64'(rand_ena[0]), 1);
        check_word("w1");
        for (int k = 0; k < 3; k++) begin
            tick();
            m_step();
            check_word("run");
        end

        rand_ready = 0;
        snap_phase = rand_phase;
        snap_ena = rand_ena;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rand_phase !== snap_phase || rand_ena !== snap_ena || !rand_valid) bad++;
        end
        check("bp_hold_cycles_bad", 64'(bad), 0);
        check_word("bp_held");
        rand_ready = 1;
        tick();
        m_step();
        check_word("bp_resume");

        #3;
        reset_n = 0;
        #1;
        check("arst_valid", 64'(rand_valid), 0);
        check("arst_busy", 64'(busy), 0);
        check("arst_phase", 64'(rand_phase), 0);
        check("arst_ena", 64'(rand_ena), 0);
        check("arst_done", 64'(done), 0);
        m_seed(32'hACE1_2024);
        @(posedge clk);
        #1;
        reset_n = 1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rand_valid || busy || done) bad++;
        end
        check("post_rst_idle_bad", 64'(bad), 0);

        init_prob = 8'd0;
        start = 1;
        tick();
        start = 0;
        check("zero_done", 64'(done), 1);
        check("zero_valid", 64'(rand_valid), 0);
        check("zero_busy", 64'(busy), 0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rand_valid || busy || !done) bad++;
        end
        check("zero_hold_bad", 64'(bad), 0);

        init_prob = 8'd3;
        decay_shift = 3'd1;
        start = 1;
        tick();
        start = 0;
        words = 0;
        for (int c = 0; c < 40 && rand_valid; c++) begin
            m_prob = (words < 4) ? 8'd3 : (words < 8) ? 8'd2 : 8'd1;
            check_word("decay");
            words++;
            m_step();
            tick();
        end
        check("decay_words", 64'(words), 12);
        check("decay_done", 64'(done), 1);
        check("decay_valid", 64'(rand_valid), 0);

        init_prob = 8'd128;
        decay_shift = 3'd0;
        start = 1;
        tick();
        start = 0;
        m_prob = 8'd128;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (!busy || done || rand_phase !== exp_phase() || rand_ena !== exp_ena()) bad++;
            m_step();
            tick();
        end
        check("nodecay_bad", 64'(bad), 0);
        check("nodecay_busy", 64'(busy), 1);

        #3;
        reset_n = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        m_seed(32'hACE1_2024);
        tick();
        check("restart_idle_valid", 64'(rand_valid), 0);
        start = 1;
        tick();
        start = 0;
        check("restart_pe0_phase", 64'(rand_phase[3:0]), 64'h4);
        check("restart_pe1_phase", 64'(rand_phase[7:4]), 64'hD);
        check("restart_pe01_ena", 64'(rand_ena[1:0]), 64'h2);
        check_word("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
